// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 channel mux with a bounded burst per grant.
// Optional beat/grant statistics counters are built when MUX4_ARB_STATS_EN is defined.

module mux4_rr_lane #(
  parameter int WIDTH = 2
) (
  input  logic             sel_hit,
  input  logic             busy,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             ready,
  output logic             valid_fwd,
  output logic [WIDTH-1:0] data_fwd
);
  // Only the selected lane contributes; the others stay zero so the top can OR-reduce.
  assign ready     = busy & sel_hit & out_ready;
  assign valid_fwd = busy & sel_hit & valid;
  assign data_fwd  = sel_hit ? data : '0;
endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         io_req_valid,
  input  logic [4*WIDTH-1:0] io_req_data,
  output logic [3:0]         io_req_ready,
  output logic               io_out_valid,
  output logic [WIDTH-1:0]   io_out_data,
  input  logic               io_out_ready,
  output logic [1:0]         io_sel,
  output logic               io_busy
`ifdef MUX4_ARB_STATS_EN
  ,
  output logic [15:0]        io_beat_count,
  output logic [15:0]        io_grant_count
`endif
);
  localparam int NUM_LANES = 4;
  localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] sel, sel_n, last, last_n;
  logic [3:0] cnt, cnt_n;
  logic       busy, hs, release_now, grant_edge;

  logic [NUM_LANES-1:0][WIDTH-1:0] req_data, data_fwd;
  logic [NUM_LANES-1:0]            valid_fwd;

  assign req_data = io_req_data;
  assign busy     = (state == GRANT);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      mux4_rr_lane #(.WIDTH(WIDTH)) u_lane (
        .sel_hit   (sel == 2'(gi)),
        .busy      (busy),
        .valid     (io_req_valid[gi]),
        .data      (req_data[gi]),
        .out_ready (io_out_ready),
        .ready     (io_req_ready[gi]),
        .valid_fwd (valid_fwd[gi]),
        .data_fwd  (data_fwd[gi])
      );
    end
  endgenerate

  always_comb begin
    io_out_data = '0;
    for (int i = 0; i < NUM_LANES; i++) io_out_data = io_out_data | data_fwd[i];
  end

  assign io_out_valid = |valid_fwd;
  assign io_sel       = sel;
  assign io_busy      = busy;
  assign hs           = io_out_valid & io_out_ready;

  // First valid index after base, so base itself is scanned last.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign release_now = busy & (~io_req_valid[sel] | (hs & (cnt == LAST_BEAT)));

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    last_n     = last;
    cnt_n      = cnt;
    grant_edge = 1'b0;
    case (state)
      IDLE: begin
        if (|io_req_valid) begin
          state_n    = GRANT;
          sel_n      = rr_pick(io_req_valid, last);
          last_n     = sel_n;
          cnt_n      = '0;
          grant_edge = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          cnt_n = '0;
          // The releasing index becomes the new base before picking.
          if (|io_req_valid) begin
            sel_n      = rr_pick(io_req_valid, sel);
            last_n     = sel_n;
            grant_edge = 1'b1;
          end else begin
            state_n = IDLE;
            last_n  = sel;
          end
        end else if (hs) begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= 2'd0;
      last  <= 2'd3;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

`ifdef MUX4_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_beat_count  <= 16'd0;
      io_grant_count <= 16'd0;
    end else begin
      if (hs)         io_beat_count  <= io_beat_count + 16'd1;
      if (grant_edge) io_grant_count <= io_grant_count + 16'd1;
    end
  end
`else
  logic unused_grant_edge;
  assign unused_grant_edge = grant_edge;
`endif

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 WIDTH-bit channel mux.
- Four requesters present data with valid/ready handshakes; the block grants one at a time and drives the mux select.
- It forwards the granted requester's data and handshake to a single downstream consumer, with a bounded burst length per grant.
- Sits between the switch/requester logic and the parameterized mux instance; io_sel connects directly to the mux select input.

Parameters:
- WIDTH, 2: data width per requester and of io_out_data.
- MAX_HOLD, 4: maximum handshakes per grant before forced release; legal range 1..15.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserts immediately when low, releases synchronously to clock).
- io_req_valid  input  4  bit i = requester i has data.
- io_req_data  input  4*WIDTH  requester i data at bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- io_req_ready  output  4  bit i = requester i handshake accepted this cycle if valid.
- io_out_valid  output  1  forwarded valid of granted requester.
- io_out_data  output  WIDTH  forwarded data of granted requester (mux output).
- io_out_ready  input  1  downstream ready.
- io_sel  output  2  registered grant index; drives the mux select.
- io_busy  output  1  high in GRANT state.

Behaviour:
- States: IDLE, GRANT. Registers: state, sel[1:0], last[1:0], cnt[3:0].
- Reset values: state=IDLE, sel=0, last=3, cnt=0.
  - Outputs under reset: io_req_ready=0, io_out_valid=0, io_busy=0, io_sel=0.
  - io_out_data = req_data slice 0.
- Round-robin pick:
  - Scan indices last+1, last+2, last+3, last+4 (mod 4).
  - The first index with valid set wins; the just-released index therefore has lowest priority.
- IDLE:
  - io_out_valid=0 and io_req_ready=0.
  - If any io_req_valid is set, the next edge sets sel=pick, last=pick, cnt=0, state=GRANT.
  - Latency: valid rising to io_out_valid is 1 cycle.
- GRANT (combinational forwarding, zero added latency):
  - io_out_valid = io_req_valid[sel].
  - io_out_data = data slice sel.
  - io_req_ready[sel] = io_out_ready; all other ready bits are 0.
- Handshake:
  - A handshake occurs when io_out_valid and io_out_ready are both high.
  - Each handshake increments cnt.
- Release, evaluated at each GRANT edge:
  - (a) io_req_valid[sel]=0.
  - (b) handshake while cnt==MAX_HOLD-1.
- On release:
  - cnt=0.
  - If any valid exists, jump directly to GRANT with the new pick (no IDLE bubble); sel and last update.
  - If no valid exists, go to IDLE.
  - Evaluate the pick using the current cycle's valids, with last updated to the releasing sel first.
- Simultaneous (b) release with the same requester still valid and no others valid: re-grant the same requester with cnt=0.
- io_sel holds its last value in IDLE; it changes only on a grant edge.
- A requester may not drop valid mid-burst without penalty: dropping valid loses its grant per (a).
- Downstream stall: cnt holds and the grant persists while io_out_ready=0 and valid remains high, with no timeout.
- Reset mid-burst: reset immediately forces IDLE and the reset values; any in-flight beat is not accepted (ready=0).

Optional Feature:
- Macro: MUX4_ARB_STATS_EN.
- Defined:
  - Adds output io_beat_count (16-bit) counting total handshakes, wrapping at 0xFFFF->0.
  - Adds output io_grant_count (16-bit) counting grant edges, wrapping.
  - Both counters reset to 0 on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then req_valid=0001, out_ready=1 continuously:
  - cycle 1 io_sel=0, io_busy=1.
  - Beats 1-4 pass with io_req_ready=0001.
  - After the 4th beat, requester 0 is re-granted with cnt=0 (the only requester).
- req_valid=1111 held, out_ready=1, MAX_HOLD=4:
  - Grant order 0,1,2,3,0.
  - Each grant gives exactly 4 handshakes with no idle cycle between grants.
- Grant to 2 with out_ready=0 for 10 cycles:
  - io_out_valid=1, cnt stays 0, io_sel=2 throughout.
  - Raising ready resumes the beats.
- Granted requester 1 drops valid after 2 beats while 3 is valid:
  - Next edge io_sel=3, last=3.
  - Requester 1 is not re-granted before 0 (if valid).
- Reset low during GRANT mid-burst:
  - Same cycle: io_out_valid=0, io_req_ready=0000, io_sel=0, io_busy=0.
  - After release: first grant goes to the lowest valid index from 0.
- With MUX4_ARB_STATS_EN: 4 requesters x 4 beats gives io_beat_count=16, io_grant_count=4.
